// File: rtl/fpnew_pkg.sv
// Shared FP definitions for the non-computational slice: formats, operand
// classification info and the RISC-V FCLASS mask encoder.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
    logic is_boxed;
  } fp_info_t;

  localparam int unsigned NUM_FCLASS_BITS = 10;

  typedef enum logic [3:0] {
    CLASS_NEG_INF       = 4'd0,
    CLASS_NEG_NORMAL    = 4'd1,
    CLASS_NEG_SUBNORMAL = 4'd2,
    CLASS_NEG_ZERO      = 4'd3,
    CLASS_POS_ZERO      = 4'd4,
    CLASS_POS_SUBNORMAL = 4'd5,
    CLASS_POS_NORMAL    = 4'd6,
    CLASS_POS_INF       = 4'd7,
    CLASS_SNAN          = 4'd8,
    CLASS_QNAN          = 4'd9
  } classmask_e;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

  // NaN classes take priority so the sign never leaks into bits 8/9; an
  // unboxed operand arrives here as a quiet NaN.
  function automatic logic [NUM_FCLASS_BITS-1:0] fclass_encode(fp_info_t info, logic sign);
    logic [NUM_FCLASS_BITS-1:0] mask;
    classmask_e idx;
    if (info.is_nan)            idx = info.is_signalling ? CLASS_SNAN : CLASS_QNAN;
    else if (info.is_inf)       idx = sign ? CLASS_NEG_INF       : CLASS_POS_INF;
    else if (info.is_zero)      idx = sign ? CLASS_NEG_ZERO      : CLASS_POS_ZERO;
    else if (info.is_subnormal) idx = sign ? CLASS_NEG_SUBNORMAL : CLASS_POS_SUBNORMAL;
    else                        idx = sign ? CLASS_NEG_NORMAL    : CLASS_POS_NORMAL;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/fpnew_fclass_unit_if.sv
// Handshake bundle around the FCLASS stage: operand/tag in, class mask/tag out.
interface fpnew_fclass_unit_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned TagWidth = 4
);
  logic [WIDTH-1:0]                     operand;
  logic                                 is_boxed;
  logic [TagWidth-1:0]                  tag_in;
  logic                                 in_valid;
  logic                                 in_ready;
  logic                                 flush;
  logic [fpnew_pkg::NUM_FCLASS_BITS-1:0] class_mask;
  logic [TagWidth-1:0]                  tag_out;
  logic                                 out_valid;
  logic                                 out_ready;
  logic                                 busy;

  modport master (
    output operand, is_boxed, tag_in, in_valid, flush, out_ready,
    input  in_ready, class_mask, tag_out, out_valid, busy
  );

  modport slave (
    input  operand, is_boxed, tag_in, in_valid, flush, out_ready,
    output in_ready, class_mask, tag_out, out_valid, busy
  );
endinterface

// File: rtl/fpnew_classifier.sv
// Per-operand classifier: decodes exponent/mantissa fields into fp_info_t.
module fpnew_classifier
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat    = FP32,
  parameter int unsigned NumOperands = 1,
  localparam int unsigned WIDTH      = fp_width(FpFormat)
) (
  input  logic     [NumOperands-1:0][WIDTH-1:0] operands_i,
  input  logic     [NumOperands-1:0]            is_boxed_i,
  output fp_info_t [NumOperands-1:0]            info_o
);

  localparam int unsigned EXP_BITS = exp_bits(FpFormat);
  localparam int unsigned MAN_BITS = man_bits(FpFormat);

  for (genvar i = 0; i < NumOperands; i++) begin : gen_operand
    logic [EXP_BITS-1:0] exponent;
    logic [MAN_BITS-1:0] mantissa;
    logic                exp_zero, exp_ones, man_zero;
    logic                unused_sign;
    fp_info_t            info;

    assign exponent    = operands_i[i][WIDTH-2 -: EXP_BITS];
    assign mantissa    = operands_i[i][MAN_BITS-1:0];
    assign unused_sign = operands_i[i][WIDTH-1];
    assign exp_zero    = (exponent == '0);
    assign exp_ones    = (exponent == '1);
    assign man_zero    = (mantissa == '0);

    // NOTE: every field gets a default before the decode so no path can infer a latch.
    always_comb begin
      info               = '0;
      info.is_boxed      = is_boxed_i[i];
      info.is_normal     = is_boxed_i[i] & ~exp_zero & ~exp_ones;
      info.is_zero       = is_boxed_i[i] & exp_zero & man_zero;
      info.is_subnormal  = is_boxed_i[i] & exp_zero & ~man_zero;
      info.is_inf        = is_boxed_i[i] & exp_ones & man_zero;
      info.is_nan        = ~is_boxed_i[i] | (exp_ones & ~man_zero);
      info.is_signalling = is_boxed_i[i] & exp_ones & ~man_zero & ~mantissa[MAN_BITS-1];
      info.is_quiet      = info.is_nan & ~info.is_signalling;
    end

    assign info_o[i] = info;
  end

endmodule

// File: rtl/fpnew_fclass_unit.sv
// FCLASS execution stage: classify, encode the 10-bit mask, then carry it
// through NumPipeRegs valid/ready register stages with flush and tag passthrough.
module fpnew_fclass_unit
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat    = fp_format_e'(0),
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 4,
  localparam int unsigned WIDTH      = fp_width(FpFormat)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [WIDTH-1:0]           operand_i,
  input  logic                       is_boxed_i,
  input  logic [TagWidth-1:0]        tag_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       flush_i,
  output logic [NUM_FCLASS_BITS-1:0] class_o,
  output logic [TagWidth-1:0]        tag_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       busy_o
);

  fp_info_t [0:0]             info;
  logic [NUM_FCLASS_BITS-1:0] class_in;

  fpnew_classifier #(
    .FpFormat    (FpFormat),
    .NumOperands (1)
  ) i_classifier (
    .operands_i (operand_i),
    .is_boxed_i (is_boxed_i),
    .info_o     (info)
  );

  assign class_in = fclass_encode(info[0], operand_i[WIDTH-1]);

  if (NumPipeRegs == 0) begin : gen_comb
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, flush_i};
    assign in_ready_o  = out_ready_i;
    assign out_valid_o = in_valid_i;
    assign class_o     = class_in;
    assign tag_o       = tag_i;
    assign busy_o      = 1'b0;
  end else begin : gen_pipe
    logic [NumPipeRegs-1:0]     stage_valid;
    logic [NUM_FCLASS_BITS-1:0] stage_class [NumPipeRegs];
    logic [TagWidth-1:0]        stage_tag   [NumPipeRegs];
    logic [NumPipeRegs:0]       ready;

    // Ready ripples backwards in one block so a full pipe still accepts a push
    // in the same cycle the tail pops.
    always_comb begin
      ready              = '0;
      ready[NumPipeRegs] = out_ready_i;
      for (int k = int'(NumPipeRegs) - 1; k >= 0; k--) begin
        ready[k] = ~stage_valid[k] | ready[k+1];
      end
    end

    for (genvar k = 0; k < NumPipeRegs; k++) begin : gen_stage
      logic                       prev_valid;
      logic [NUM_FCLASS_BITS-1:0] prev_class;
      logic [TagWidth-1:0]        prev_tag;
      logic                       valid_d, valid_q;
      logic [NUM_FCLASS_BITS-1:0] class_d, class_q;
      logic [TagWidth-1:0]        tag_d, tag_q;

      if (k == 0) begin : gen_head
        assign prev_valid = in_valid_i;
        assign prev_class = class_in;
        assign prev_tag   = tag_i;
      end else begin : gen_body
        assign prev_valid = stage_valid[k-1];
        assign prev_class = stage_class[k-1];
        assign prev_tag   = stage_tag[k-1];
      end

      always_comb begin
        valid_d = valid_q;
        class_d = class_q;
        tag_d   = tag_q;
        if (ready[k]) valid_d = prev_valid;
        if (ready[k] && prev_valid) begin
          class_d = prev_class;
          tag_d   = prev_tag;
        end
        if (flush_i) valid_d = 1'b0;
      end

      // NOTE: data registers are reset too, because class_o/tag_o must read zero out of reset.
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          valid_q <= 1'b0;
          class_q <= '0;
          tag_q   <= '0;
        end else begin
          valid_q <= valid_d;
          class_q <= class_d;
          tag_q   <= tag_d;
        end
      end

      assign stage_valid[k] = valid_q;
      assign stage_class[k] = class_q;
      assign stage_tag[k]   = tag_q;
    end

    assign in_ready_o  = ready[0];
    assign out_valid_o = stage_valid[NumPipeRegs-1];
    assign class_o     = stage_class[NumPipeRegs-1];
    assign tag_o       = stage_tag[NumPipeRegs-1];
    assign busy_o      = |stage_valid;
  end

endmodule
